// File: rtl/pla_sweep_driver.sv
// rtl/pla_sweep_driver.sv - exhaustive 10-input sweep driver and truth-table word collector
//
// Ports:
//   clk, rst        rising-edge clock, synchronous active-high reset
//   start           begin a sweep (honoured only when idle or done)
//   x0..x9          current vector to the netlist, x0 = LSB
//   y0              netlist response
//   word_data       captured 32-bit truth-table word (bit k = vector word_index*32+k)
//   word_index      index of the presented word
//   word_valid      word_data/word_index valid; held until word_ready
//   word_ready      consumer accepts the presented word
//   ones_count      running count of y0=1 samples in this sweep
//   busy, done      sweep in progress / sweep complete

module pla_sweep_driver #(
  parameter int SETTLE = 1
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        start,
  output logic        x0,
  output logic        x1,
  output logic        x2,
  output logic        x3,
  output logic        x4,
  output logic        x5,
  output logic        x6,
  output logic        x7,
  output logic        x8,
  output logic        x9,
  input  logic        y0,
  output logic [31:0] word_data,
  output logic [4:0]  word_index,
  output logic        word_valid,
  input  logic        word_ready,
  output logic [10:0] ones_count,
  output logic        busy,
  output logic        done
);

  // Last hold cycle of a vector; y0 is sampled on the edge that ends it.
  localparam logic [3:0] HOLD_LAST = 4'(SETTLE);

  typedef enum logic [1:0] {
    IDLE,
    APPLY,
    EMIT,
    DONE
  } state_t;

  state_t      state;
  logic [9:0]  v;       // current vector index
  logic [3:0]  hold;    // cycles the current vector has been held
  logic [31:0] shreg;   // word under construction
  logic [9:0]  xr;      // registered copy of the vector driven on x

  assign {x9, x8, x7, x6, x5, x4, x3, x2, x1, x0} = xr;

  always_ff @(posedge clk) begin
    if (rst) begin
      state      <= IDLE;
      v          <= '0;
      hold       <= '0;
      shreg      <= '0;
      xr         <= '0;
      word_data  <= '0;
      word_index <= '0;
      word_valid <= 1'b0;
      ones_count <= '0;
      busy       <= 1'b0;
      done       <= 1'b0;
    end else begin
      case (state)
        IDLE, DONE: begin
          // A restart from DONE clears everything a reset would, so the
          // first word's APPLY phase always presents word_data = 0.
          if (start) begin
            state      <= APPLY;
            v          <= '0;
            hold       <= '0;
            shreg      <= '0;
            xr         <= '0;
            word_data  <= '0;
            word_index <= '0;
            word_valid <= 1'b0;
            ones_count <= '0;
            busy       <= 1'b1;
            done       <= 1'b0;
          end
        end

        APPLY: begin
          if (hold == HOLD_LAST) begin
            hold          <= '0;
            shreg[v[4:0]] <= y0;
            ones_count    <= ones_count + {10'd0, y0};
            if (v[4:0] == 5'd31) begin
              // The final bit goes straight into the presented word since
              // the shift-register write lands on the same edge.
              state      <= EMIT;
              word_data  <= {y0, shreg[30:0]};
              word_index <= v[9:5];
              word_valid <= 1'b1;
            end else begin
              v  <= v + 10'd1;
              xr <= v + 10'd1;
            end
          end else begin
            hold <= hold + 4'd1;
          end
        end

        EMIT: begin
          // Everything is frozen until the consumer takes the word.
          if (word_ready) begin
            word_valid <= 1'b0;
            if (v == 10'd1023) begin
              state <= DONE;
              xr    <= '0;
              busy  <= 1'b0;
              done  <= 1'b1;
            end else begin
              state <= APPLY;
              v     <= v + 10'd1;
              xr    <= v + 10'd1;
            end
          end
        end

        default: state <= IDLE;
      endcase
    end
  end

endmodule
